// File: rtl/outlier_pkg.sv
// rtl/outlier_pkg.sv - shared sizes, index type and FSM states for outlier_index_gen
package outlier_pkg;
    localparam int DIMM   = 64;
    localparam int NUM_LR = 4;
    localparam int LANES  = 8;
    localparam int IDX_W  = $clog2(DIMM);
    localparam int NCHUNK = DIMM / LANES;
    localparam int C_W    = $clog2(NCHUNK);
    localparam int CNT_W  = $clog2(DIMM + 1);
    localparam int M_W    = $clog2(NUM_LR + 1);
    localparam int OB_W   = $clog2(NUM_LR);
    localparam int HIT_W  = $clog2(LANES + 1);

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } state_t;
endpackage

// File: rtl/chunk_compactor.sv
// rtl/chunk_compactor.sv - combinational per-chunk split of lanes into outlier/inlier slots
module chunk_compactor
    import outlier_pkg::*;
(
    input  logic [LANES-1:0] i_flags,
    input  logic [M_W-1:0]   i_opos,
    input  logic [CNT_W-1:0] i_ipos,
    output logic [LANES-1:0] o_to_obuf,
    output idx_t             o_slot [LANES],
    output logic [M_W-1:0]   o_opos,
    output logic [CNT_W-1:0] o_ipos,
    output logic [HIT_W-1:0] o_hits
);
    // Running positions act as the within-chunk prefix counts; opos saturation
    // mid-chunk pushes the remaining flagged lanes into the inlier buffer.
    always_comb begin
        o_opos    = i_opos;
        o_ipos    = i_ipos;
        o_hits    = '0;
        o_to_obuf = '0;
        for (int l = 0; l < LANES; l++) begin
            o_slot[l] = '0;
            if (i_flags[l]) begin
                o_hits = o_hits + 1'b1;
            end
            if (i_flags[l] && (o_opos < M_W'(NUM_LR))) begin
                o_to_obuf[l] = 1'b1;
                o_slot[l]    = idx_t'(o_opos);
                o_opos       = o_opos + 1'b1;
            end else begin
                o_slot[l] = idx_t'(o_ipos);
                o_ipos    = o_ipos + 1'b1;
            end
        end
    end
endmodule

// File: rtl/outlier_index_gen.sv
// rtl/outlier_index_gen.sv - builds outlier-first lane permutation from an overflow vector
module outlier_index_gen
    import outlier_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DIMM-1:0]            in_overflow,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DIMM-1:0][IDX_W-1:0] out_index,
    output logic [M_W-1:0]             out_num_outlier,
    output logic [CNT_W-1:0]           out_outlier_cnt,
    output logic                       out_excess
);
    state_t                     r_state;
    logic [DIMM-1:0]            r_flags;
    logic [C_W-1:0]             r_c;
    logic [M_W-1:0]             r_opos;
    logic [CNT_W-1:0]           r_ipos;
    logic [CNT_W-1:0]           r_k;
    idx_t                       r_obuf [NUM_LR];
    idx_t                       r_ibuf [DIMM];
    logic                       r_out_valid;
    logic [DIMM-1:0][IDX_W-1:0] r_out_index;
    logic [M_W-1:0]             r_m;
    logic [CNT_W-1:0]           r_cnt;
    logic                       r_excess;

    idx_t                       w_base;
    logic [LANES-1:0]           w_chunk_flags;
    logic [LANES-1:0]           w_to_obuf;
    idx_t                       w_slot [LANES];
    logic [M_W-1:0]             w_opos_n;
    logic [CNT_W-1:0]           w_ipos_n;
    logic [HIT_W-1:0]           w_hits;
    logic [CNT_W-1:0]           w_k_n;
    idx_t                       w_obuf_n [NUM_LR];
    idx_t                       w_ibuf_n [DIMM];
    logic [DIMM-1:0][IDX_W-1:0] w_out_n;

    assign w_base        = idx_t'(r_c) << $clog2(LANES);
    assign w_chunk_flags = r_flags[w_base +: LANES];
    assign w_k_n         = r_k + CNT_W'(w_hits);

    chunk_compactor u_compactor (
        .i_flags   (w_chunk_flags),
        .i_opos    (r_opos),
        .i_ipos    (r_ipos),
        .o_to_obuf (w_to_obuf),
        .o_slot    (w_slot),
        .o_opos    (w_opos_n),
        .o_ipos    (w_ipos_n),
        .o_hits    (w_hits)
    );

    // Buffers as they will look after this chunk, so the final mux sees the last chunk too.
    always_comb begin
        w_obuf_n = r_obuf;
        w_ibuf_n = r_ibuf;
        for (int l = 0; l < LANES; l++) begin
            if (w_to_obuf[l]) begin
                w_obuf_n[w_slot[l][OB_W-1:0]] = w_base + idx_t'(l);
            end else begin
                w_ibuf_n[w_slot[l]] = w_base + idx_t'(l);
            end
        end
    end

    always_comb begin
        w_out_n = '0;
        for (int j = 0; j < DIMM; j++) begin
            if (j < int'(w_opos_n)) begin
                w_out_n[j] = w_obuf_n[OB_W'(j)];
            end else begin
                w_out_n[j] = w_ibuf_n[IDX_W'(j - int'(w_opos_n))];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_flags     <= '0;
            r_c         <= '0;
            r_opos      <= '0;
            r_ipos      <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_m         <= '0;
            r_cnt       <= '0;
            r_excess    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_flags <= in_overflow;
                        r_c     <= '0;
                        r_opos  <= '0;
                        r_ipos  <= '0;
                        r_k     <= '0;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    r_obuf <= w_obuf_n;
                    r_ibuf <= w_ibuf_n;
                    r_opos <= w_opos_n;
                    r_ipos <= w_ipos_n;
                    r_k    <= w_k_n;
                    r_c    <= r_c + 1'b1;
                    if (r_c == C_W'(NCHUNK - 1)) begin
                        r_state     <= OUT;
                        r_out_valid <= 1'b1;
                        r_out_index <= w_out_n;
                        r_m         <= w_opos_n;
                        r_cnt       <= w_k_n;
                        r_excess    <= (w_k_n > CNT_W'(NUM_LR));
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready        = (r_state == IDLE) && !rst;
    assign out_valid       = r_out_valid;
    assign out_index       = r_out_index;
    assign out_num_outlier = r_m;
    assign out_outlier_cnt = r_cnt;
    assign out_excess      = r_excess;
endmodule

// File: tb/tb_outlier_index_gen.sv
// tb/tb_outlier_index_gen.sv - directed table-driven bench for outlier_index_gen
module tb_outlier_index_gen;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [63:0]      in_overflow = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [63:0][5:0] out_index;
    logic [2:0]       out_num_outlier;
    logic [6:0]       out_outlier_cnt;
    logic             out_excess;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [63:0] flags;
        int          m;
        int          k;
        int          ex;
        int          pos [6];
        int          val [6];
    } vec_t;

    vec_t tv [6];

    outlier_index_gen dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_overflow     (in_overflow),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_index       (out_index),
        .out_num_outlier (out_num_outlier),
        .out_outlier_cnt (out_outlier_cnt),
        .out_excess      (out_excess)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [383:0] act, input logic [383:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Outlier-first permutation: first NUM_LR flagged lanes, then every other lane.
    function automatic logic [63:0][5:0] ref_perm(input logic [63:0] f);
        logic [63:0][5:0] r;
        logic [63:0]      picked;
        int               n;
        r = '0;
        picked = '0;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if (f[i] && n < 4) begin
                r[n] = 6'(i);
                picked[i] = 1'b1;
                n++;
            end
        end
        for (int i = 0; i < 64; i++) begin
            if (!picked[i]) begin
                r[n] = 6'(i);
                n++;
            end
        end
        return r;
    endfunction

    task automatic send_and_wait(input logic [63:0] f, output int lat);
        @(negedge clk);
        in_overflow = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("%s out_valid after handshake", tag), longint'(out_valid), 0);
        check($sformatf("%s in_ready after handshake", tag), longint'(in_ready), 1);
    endtask

    task automatic run_vec(input int i);
        int lat;
        send_and_wait(tv[i].flags, lat);
        check($sformatf("v%0d latency", i), lat, 8);
        check($sformatf("v%0d m", i), longint'(out_num_outlier), tv[i].m);
        check($sformatf("v%0d k", i), longint'(out_outlier_cnt), tv[i].k);
        check($sformatf("v%0d excess", i), longint'(out_excess), tv[i].ex);
        for (int s = 0; s < 6; s++) begin
            check($sformatf("v%0d out_index[%0d]", i, tv[i].pos[s]),
                  longint'(out_index[tv[i].pos[s]]), tv[i].val[s]);
        end
        check_vec($sformatf("v%0d full permutation", i), out_index, ref_perm(tv[i].flags));
        handshake($sformatf("v%0d", i));
    endtask

    initial begin
        logic [63:0][5:0] snap;
        int               lat;
        int               highs;

        tv[0] = '{64'h0000_0100_0000_0020, 2, 2, 0, '{0, 1, 2, 3, 4, 63},  '{5, 40, 0, 1, 2, 63}};
        tv[1] = '{64'h8000_0000_0000_0188, 4, 4, 0, '{0, 1, 2, 3, 4, 7},   '{3, 7, 8, 63, 0, 4}};
        tv[2] = '{64'h0000_0000_003F_0000, 4, 6, 1, '{0, 3, 4, 19, 20, 21}, '{16, 19, 0, 15, 20, 21}};
        tv[3] = '{64'h0000_0000_0000_0000, 0, 0, 0, '{0, 1, 5, 31, 32, 63}, '{0, 1, 5, 31, 32, 63}};
        tv[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 4, 64, 1, '{0, 3, 4, 10, 62, 63}, '{0, 3, 4, 10, 62, 63}};
        tv[5] = '{64'h0000_0000_0000_0607, 4, 5, 1, '{0, 1, 2, 3, 9, 10},  '{0, 1, 2, 9, 8, 10}};

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", longint'(in_ready), 0);
        check("reset out_valid", longint'(out_valid), 0);
        check_vec("reset out_index", out_index, '0);
        check("reset out_num_outlier", longint'(out_num_outlier), 0);
        check("reset out_outlier_cnt", longint'(out_outlier_cnt), 0);
        check("reset out_excess", longint'(out_excess), 0);
        rst = 1'b0;
        #1;
        check("idle in_ready", longint'(in_ready), 1);

        for (int i = 0; i < 6; i++) begin
            run_vec(i);
        end

        // Backpressure: outputs hold, new vectors are refused, then in_ready returns.
        send_and_wait(tv[0].flags, lat);
        check("bp latency", lat, 8);
        snap = out_index;
        out_ready = 1'b0;
        in_overflow = 64'hFFFF_FFFF_FFFF_FFFF;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp cyc%0d out_valid", c), longint'(out_valid), 1);
            check($sformatf("bp cyc%0d in_ready", c), longint'(in_ready), 0);
            check_vec($sformatf("bp cyc%0d out_index", c), out_index, snap);
            check($sformatf("bp cyc%0d k", c), longint'(out_outlier_cnt), 2);
        end
        in_valid = 1'b0;
        handshake("bp");
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) highs++;
        end
        check("bp ignored vector produced no output", highs, 0);

        // Reset after three scan cycles drops the in-flight vector.
        @(negedge clk);
        in_overflow = tv[2].flags;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midreset in_ready during rst", longint'(in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midreset out_valid", longint'(out_valid), 0);
        check("midreset in_ready", longint'(in_ready), 1);
        check("midreset k cleared", longint'(out_outlier_cnt), 0);
        highs = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) highs++;
        end
        check("midreset no output emitted", highs, 0);
        run_vec(1);
        run_vec(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
